// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 8-bit CPU microsequencer: control-bit indices,
// opcode values, micro-step and phase encodings.
package cpu_ctrl_pkg;

    localparam int CW_WIDTH = 25;
    localparam int OP_WIDTH = 8;

    // Control-bus bit positions read by the datapath blocks
    localparam int CB_MAR_PC  = 0;
    localparam int CB_MBR_MEM = 1;
    localparam int CB_MEM_MBR = 2;
    localparam int CB_IR_MBR  = 3;
    localparam int CB_PC_INC  = 4;
    localparam int CB_PC_MBR  = 5;
    localparam int CB_PC_CLR  = 6;
    localparam int CB_MAR_MBR = 7;
    localparam int CB_ACC_CLR = 8;
    localparam int CB_ACC_ADD = 9;
    localparam int CB_ACC_SUB = 10;
    localparam int CB_BR_MBR  = 11;
    localparam int CB_ACC_BR  = 12;
    localparam int CB_MBR_ACC = 13;
    localparam int CB_ACC_SHL = 14;
    localparam int CB_ACC_SHR = 15;
    localparam int CB_ACC_AND = 16;
    localparam int CB_ACC_OR  = 17;
    localparam int CB_ACC_NOT = 18;
    localparam int CB_ACC_MUL = 19;

    typedef logic [CW_WIDTH-1:0] cword_t;
    typedef logic [OP_WIDTH-1:0] opcode_t;

    localparam opcode_t OP_STORE  = 8'h01;
    localparam opcode_t OP_LOAD   = 8'h02;
    localparam opcode_t OP_ADD    = 8'h03;
    localparam opcode_t OP_SUB    = 8'h04;
    localparam opcode_t OP_JMPGEZ = 8'h05;
    localparam opcode_t OP_JMP    = 8'h06;
    localparam opcode_t OP_HALT   = 8'h07;
    localparam opcode_t OP_MPY    = 8'h08;
    localparam opcode_t OP_AND    = 8'h09;
    localparam opcode_t OP_OR     = 8'h0A;
    localparam opcode_t OP_NOT    = 8'h0B;
    localparam opcode_t OP_SHR    = 8'h0C;
    localparam opcode_t OP_SHL    = 8'h0D;

    typedef enum logic [4:0] {
        US_IDLE,
        US_CLR,
        US_FETCH1,
        US_FETCH2,
        US_FETCH3,
        US_DECODE,
        US_M1,
        US_M2,
        US_M3,
        US_OPX,
        US_ST1,
        US_ST2,
        US_ST3,
        US_JMP,
        US_JGEZ,
        US_HALT
    } ustep_t;

    typedef enum logic {
        PH_EXEC,
        PH_GAP
    } phase_t;

    function automatic cword_t cbit(input int idx);
        return cword_t'(1) << idx;
    endfunction

    // Opcodes that fetch an operand through MAR/MBR/BR before their ALU step
    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_MPY)  || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Opcodes whose whole execute phase is a single ALU step
    function automatic logic is_acc_op(input opcode_t op);
        return (op == OP_NOT) || (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/cpu_uop_rom.sv
// Combinational micro-op table: for a micro-step, the control word it emits
// during EXEC and the micro-step that follows it.
module cpu_uop_rom
    import cpu_ctrl_pkg::*;
(
    input  ustep_t  step,
    input  opcode_t opcode,
    input  logic    acc_neg,
    output cword_t  word,
    output ustep_t  next_step
);

    // NOTE: every output gets a default before the case so no path through
    // the block leaves a value unassigned, which would infer a latch.
    always_comb begin
        word      = '0;
        next_step = US_FETCH1;
        case (step)
            US_IDLE: next_step = US_CLR;
            US_CLR: begin
                word      = cbit(CB_PC_CLR);
                next_step = US_FETCH1;
            end
            US_FETCH1: begin
                word      = cbit(CB_MAR_PC);
                next_step = US_FETCH2;
            end
            US_FETCH2: begin
                word      = cbit(CB_MBR_MEM) | cbit(CB_PC_INC);
                next_step = US_FETCH3;
            end
            US_FETCH3: begin
                word      = cbit(CB_IR_MBR);
                next_step = US_DECODE;
            end
            US_DECODE: begin
                if (is_mem_op(opcode))
                    next_step = US_M1;
                else if (is_acc_op(opcode))
                    next_step = US_OPX;
                else if (opcode == OP_STORE)
                    next_step = US_ST1;
                else if (opcode == OP_JMP)
                    next_step = US_JMP;
                else if (opcode == OP_JMPGEZ)
                    next_step = US_JGEZ;
                else if (opcode == OP_HALT)
                    next_step = US_HALT;
                else
                    next_step = US_FETCH1;
            end
            US_M1: begin
                word      = cbit(CB_MAR_MBR);
                next_step = US_M2;
            end
            US_M2: begin
                word      = cbit(CB_MBR_MEM);
                next_step = US_M3;
            end
            US_M3: begin
                word      = cbit(CB_BR_MBR);
                next_step = US_OPX;
            end
            US_OPX: begin
                case (opcode)
                    OP_LOAD: word = cbit(CB_ACC_BR);
                    OP_ADD:  word = cbit(CB_ACC_ADD);
                    OP_SUB:  word = cbit(CB_ACC_SUB);
                    OP_MPY:  word = cbit(CB_ACC_MUL);
                    OP_AND:  word = cbit(CB_ACC_AND);
                    OP_OR:   word = cbit(CB_ACC_OR);
                    OP_NOT:  word = cbit(CB_ACC_NOT);
                    OP_SHR:  word = cbit(CB_ACC_SHR);
                    OP_SHL:  word = cbit(CB_ACC_SHL);
                    default: word = '0;
                endcase
                next_step = US_FETCH1;
            end
            US_ST1: begin
                word      = cbit(CB_MAR_MBR);
                next_step = US_ST2;
            end
            US_ST2: begin
                word      = cbit(CB_MBR_ACC);
                next_step = US_ST3;
            end
            US_ST3: begin
                word      = cbit(CB_MEM_MBR);
                next_step = US_FETCH1;
            end
            US_JMP: begin
                word      = cbit(CB_PC_MBR);
                next_step = US_FETCH1;
            end
            US_JGEZ: begin
                word      = acc_neg ? '0 : cbit(CB_PC_MBR);
                next_step = US_FETCH1;
            end
            // HALT resumes at FETCH1 without clearing PC
            US_HALT: next_step = US_FETCH1;
            default: begin
                word      = '0;
                next_step = US_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Microsequencer for the 8-bit CPU: each micro-step is a one-clock control
// pulse followed by a one-clock all-zero gap, all driven from flops.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] ir_opcode,
    input  logic                acc_neg,
    output logic [CW_WIDTH-1:0] control,
    output logic                halted,
    output logic [4:0]          ustate
);

    ustep_t  step_q, step_d, seq_next;
    phase_t  phase_q, phase_d;
    opcode_t opcode_q;
    cword_t  control_q, control_d, entry_word;
    logic    halted_q;

    cword_t  unused_word;
    ustep_t  unused_next;

    // Successor of the current step
    cpu_uop_rom u_seq_rom (
        .step      (step_q),
        .opcode    (opcode_q),
        .acc_neg   (acc_neg),
        .word      (unused_word),
        .next_step (seq_next)
    );

    // Word of the step being entered, so it lands in the output flop on the
    // same edge the step begins
    cpu_uop_rom u_word_rom (
        .step      (step_d),
        .opcode    (opcode_q),
        .acc_neg   (acc_neg),
        .word      (entry_word),
        .next_step (unused_next)
    );

    always_comb begin
        step_d  = step_q;
        phase_d = phase_q;
        if (step_q == US_IDLE || step_q == US_HALT) begin
            if (start) begin
                step_d  = seq_next;
                phase_d = PH_EXEC;
            end
        end else if (phase_q == PH_EXEC) begin
            phase_d = PH_GAP;
        end else begin
            step_d  = seq_next;
            phase_d = PH_EXEC;
        end
        control_d = (phase_d == PH_EXEC) ? entry_word : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= US_IDLE;
            phase_q   <= PH_EXEC;
            control_q <= '0;
            halted_q  <= 1'b0;
            opcode_q  <= '0;
        end else begin
            step_q    <= step_d;
            phase_q   <= phase_d;
            control_q <= control_d;
            halted_q  <= (step_d == US_HALT);
            if (step_q == US_DECODE && phase_q == PH_EXEC)
                opcode_q <= ir_opcode;
        end
    end

    assign control = control_q;
    assign halted  = halted_q;
    assign ustate  = step_q;

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Microsequencer that drives the 25-bit `control` bus read by the PC, MAR, MBR, IR, BR, ACC and memory blocks of the 8-bit CPU.
- Runs fetch, decode and execute micro-steps from the IR opcode and the ACC sign flag.
- The PC and the other datapath blocks act on rising edges of individual control bits. The sequencer therefore emits each micro-step as a one-clock pulse followed by a one-clock all-zero gap. This guarantees exactly one rising edge per asserted bit, including back-to-back PC increments.

Parameters:
- CW_WIDTH, 25, control word width; fixed by the datapath bus.
- OP_WIDTH, 8, opcode width on `ir_opcode`.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse: begin execution from IDLE, or resume from HALT
- ir_opcode  input  8  opcode field of IR, stable from FETCH3 onward
- acc_neg  input  1  ACC sign bit (1 = negative)
- control  output  25  registered control word to the datapath
- halted  output  1  high while in HALT
- ustate  output  5  current micro-step encoding, for debug/bench

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low. On reset assertion, immediately: control=0, halted=0, state=IDLE, phase=EXEC. This also applies mid-instruction; no partial pulse survives.
- Control bit map:
  - bit 0 MAR<-PC; bit 1 MBR<-mem[MAR]; bit 2 mem[MAR]<-MBR; bit 3 IR<-MBR
  - bit 4 PC<-PC+1; bit 5 PC<-MBR; bit 6 PC<-0; bit 7 MAR<-MBR address field
  - bit 8 ACC<-0; bit 9 ACC<-ACC+BR; bit 10 ACC<-ACC-BR; bit 11 BR<-MBR
  - bit 12 ACC<-BR; bit 13 MBR<-ACC; bit 14 ACC shl; bit 15 ACC shr
  - bit 16 ACC&=BR; bit 17 ACC|=BR; bit 18 ACC=~ACC; bit 19 ACC*=BR
  - bits 20-24 reserved, always 0
- Two-phase micro-step:
  - Each non-idle step lasts 2 clocks: EXEC (control = step word), then GAP (control = 0).
  - The state advances at the end of GAP.
  - control is driven from flops only; no combinational path to the output.
- IDLE: control=0. start -> CLR.
- CLR: bit 6 (PC cleared) -> FETCH1.
- FETCH1: bit 0. FETCH2: bits 1|4. FETCH3: bit 3. All fall through in order.
- DECODE:
  - word 0; ir_opcode is sampled on the EXEC clock.
  - 0x01 STORE, 0x02 LOAD, 0x03 ADD, 0x04 SUB, 0x05 JMPGEZ, 0x06 JMP, 0x07 HALT, 0x08 MPY, 0x09 AND, 0x0A OR -> the sequences below.
  - 0x0B NOT -> E: bit 18.
  - 0x0C SHR -> E: bit 15.
  - 0x0D SHL -> E: bit 14.
  - Any other opcode is a NOP -> FETCH1.
- Memory-operand prefix M (LOAD/ADD/SUB/MPY/AND/OR): bit 7, then bit 1, then bit 11. The op step follows:
  - LOAD: bit 12; ADD: bit 9; SUB: bit 10; MPY: bit 19; AND: bit 16; OR: bit 17.
- STORE: bit 7, bit 13, bit 2.
- JMP: bit 5.
- JMPGEZ:
  - acc_neg is sampled on its EXEC clock.
  - acc_neg=0 -> bit 5; acc_neg=1 -> word 0 (the step still takes 2 clocks).
- Every execute sequence returns to FETCH1.
- HALT:
  - halted=1 and control=0 indefinitely.
  - start -> FETCH1 (PC is not cleared); halted drops on the same edge.
- start outside IDLE/HALT is ignored.
- No step word ever asserts both bit 5 and bit 6, or bits 4 and 5 together.
- Instruction latency: fetch+decode 8 clocks; NOT/SHR/SHL/JMP/JMPGEZ +2; STORE +6; M-ops +8.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - control-bit index constants (CB_MAR_PC ... CB_ACC_MUL)
  - CW_WIDTH
  - opcode constants OP_STORE..OP_SHL
  - micro-step enum (IDLE, CLR, FETCH1-3, DECODE, M1-M3, OPX, ST1-ST3, JMP, JGEZ, HALT)
- One sub-module, cpu_uop_rom: combinational map (step, latched opcode, acc_neg) -> {control word, next step}.
- The top level holds the step, phase and opcode registers plus the output flop.

Test Plan:
- Reset, then start pulse -> control sequence 0x040,0,0x001,0,0x012,0,0x008,0, then 0 for DECODE; halted=0 throughout.
- ir_opcode=0x03 (ADD) after fetch -> 0x080,0,0x002,0,0x800,0,0x200,0, then next fetch 0x001.
- ir_opcode=0x05, acc_neg=1 -> 2 clocks of 0, no bit-5 pulse, then 0x001. Repeat with acc_neg=0 -> 0x020 pulse.
- ir_opcode=0x07 -> halted=1, control=0 for 100 clocks, and extra start pulses at IDLE-style timing cause no CLR. start -> halted=0, next EXEC 0x001.
- ir_opcode=0xFF -> DECODE then straight to 0x001 (NOP).
- rst_n low during FETCH2 EXEC -> control=0 asynchronously before the next clk edge. After release, control stays 0 until start.
